// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer
//   Execute-stage sequencer that pushes one V-element vector operation through
//   an L-lane ALU slice in B = V/L beats, or through the full-width duplex unit
//   in a single beat when the op is 3'b111. Holds one operation at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operation handshake; in_a/in_b (V*N), in_op (3)
//   out_valid/out_ready   result handshake; out_result (V*N)
//   alu_a/alu_b/alu_op    operand slice and op to the ALU lanes (L*N)
//   alu_result            same-cycle ALU slice result (L*N)
//   dup_sel/dup_a         duplex path select and captured operand A (V*N)
//   dup_result            same-cycle duplex result (V*N)
//   busy                  an operation is in flight or waiting to be taken
module vec_alu_sequencer #(
    parameter int N = 8,
    parameter int V = 16,
    parameter int L = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [V*N-1:0] in_a,
    input  logic [V*N-1:0] in_b,
    input  logic [2:0]     in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [V*N-1:0] out_result,
    output logic [L*N-1:0] alu_a,
    output logic [L*N-1:0] alu_b,
    output logic [2:0]     alu_op,
    input  logic [L*N-1:0] alu_result,
    output logic           dup_sel,
    output logic [V*N-1:0] dup_a,
    input  logic [V*N-1:0] dup_result,
    output logic           busy
);

    localparam int B  = V / L;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);
    localparam logic [2:0] OP_DUP = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] beat;
    logic [2:0]    op_reg;

    // Beat-major views: entry [k] is the L-lane slice handled in beat k,
    // which lines up with element layout [i*N +: N] of the flat vectors.
    logic [B-1:0][L*N-1:0] a_reg;
    logic [B-1:0][L*N-1:0] b_reg;
    logic [B-1:0][L*N-1:0] res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            beat   <= '0;
            op_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            res    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg  <= in_a;
                        b_reg  <= in_b;
                        op_reg <= in_op;
                        beat   <= '0;
                        state  <= (in_op == OP_DUP) ? S_DUP : S_RUN;
                    end
                end
                S_RUN: begin
                    res[beat] <= alu_result;
                    if (beat == LAST_BEAT) state <= S_DONE;
                    else                   beat  <= beat + 1'b1;
                end
                S_DUP: begin
                    res   <= dup_result;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic run;
    assign run = (state == S_RUN);

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_result = res;

    // Slice and duplex buses are forced to zero when their path is idle so
    // downstream units never see stale captured operands.
    assign alu_a   = run ? a_reg[beat] : '0;
    assign alu_b   = run ? b_reg[beat] : '0;
    assign alu_op  = run ? op_reg : 3'b000;
    assign dup_sel = (state == S_DUP);
    assign dup_a   = dup_sel ? a_reg : '0;

endmodule
